// File: rtl/axi4_master_burst.sv
// rtl/axi4_master_burst.sv - single-command AXI4 INCR burst initiator (write or read)
module axi4_master_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic                  done,
    output logic [1:0]            resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, REJ, AW, W, B, AR, R} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            worst_resp_q, worst_resp_d;

    logic [13:0] span_bytes;
    logic [13:0] span_end;
    logic        cmd_illegal;
    logic        last_beat;
    logic [1:0]  r_merged;

    // A burst may not cross a 4KB page nor use beats wider than the bus.
    always_comb begin
        span_bytes  = (14'(cmd_len) + 14'd1) << cmd_size;
        span_end    = {2'b00, cmd_addr[11:0]} + span_bytes;
        cmd_illegal = (span_end > 14'd4096) || (int'(cmd_size) > MAX_SIZE);
    end

    assign last_beat = (beat_cnt_q == {1'b0, len_q});
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign WDATA     = wdata_in;
    assign rdata_out = RDATA;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        beat_cnt_d   = beat_cnt_q;
        worst_resp_d = worst_resp_q;
        cmd_ready    = 1'b0;
        AWVALID      = 1'b0;
        WVALID       = 1'b0;
        WLAST        = 1'b0;
        wdata_ready  = 1'b0;
        BREADY       = 1'b0;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        rdata_valid  = 1'b0;
        done         = 1'b0;
        resp         = 2'b00;
        r_merged     = worst_resp_q;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    len_d        = cmd_len;
                    size_d       = cmd_size;
                    beat_cnt_d   = 9'd0;
                    worst_resp_d = 2'b00;
                    if (cmd_illegal)    state_d = REJ;
                    else if (cmd_write) state_d = AW;
                    else                state_d = AR;
                end
            end
            REJ: begin
                done    = 1'b1;
                resp    = 2'b10;
                state_d = IDLE;
            end
            AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = W;
            end
            W: begin
                WVALID      = wdata_valid;
                wdata_ready = WREADY;
                WLAST       = last_beat;
                if (wdata_valid && WREADY) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (last_beat) state_d = B;
                end
            end
            B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    done    = 1'b1;
                    resp    = BRESP;
                    state_d = IDLE;
                end
            end
            AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = R;
            end
            R: begin
                RREADY      = rdata_ready;
                rdata_valid = RVALID;
                if (RVALID && rdata_ready) begin
                    beat_cnt_d   = beat_cnt_q + 9'd1;
                    r_merged     = (RRESP > worst_resp_q) ? RRESP : worst_resp_q;
                    worst_resp_d = r_merged;
                    if (RLAST || last_beat) begin
                        done    = 1'b1;
                        // A slave ending the burst short is reported as at least SLVERR.
                        resp    = (RLAST && !last_beat && r_merged < 2'b10) ? 2'b10 : r_merged;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            beat_cnt_q   <= '0;
            worst_resp_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            beat_cnt_q   <= beat_cnt_d;
            worst_resp_q <= worst_resp_d;
        end
    end
endmodule

// File: doc/axi4_master_burst.md
Name: axi4_master_burst

Overview:
- AXI4 initiator that turns single-command requests into one INCR burst, either write or read, on the memory-mapped slave bus.
- Sits between test or host logic and the arb_if-connected AXI4 memory slave.
- Provides a simple command port, a write-data stream in, and a read-data stream out.
- Handles one outstanding transaction at a time.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 16, byte address width.

Ports:
- ACLK in 1: clock, rising edge.
- ARESETn in 1: asynchronous active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accepted when high together with cmd_valid.
- cmd_write in 1: 1 = write burst, 0 = read burst.
- cmd_addr in ADDR_WIDTH: start byte address.
- cmd_len in 8: beats minus 1 (AXI LEN encoding).
- cmd_size in 3: log2 of bytes per beat.
- wdata_in in DATA_WIDTH: user write beat.
- wdata_valid in 1: write beat available.
- wdata_ready out 1: write beat consumed.
- rdata_out out DATA_WIDTH: read beat.
- rdata_valid out 1: read beat valid.
- rdata_ready in 1: user accepts read beat.
- done out 1: one-cycle pulse at transaction end.
- resp out 2: final response, valid while done is high.
- AWADDR out ADDR_WIDTH, AWLEN out 8, AWSIZE out 3, AWVALID out 1, AWREADY in 1: write address channel.
- WDATA out DATA_WIDTH, WVALID out 1, WLAST out 1, WREADY in 1: write data channel.
- BRESP in 2, BVALID in 1, BREADY out 1: write response channel.
- ARADDR out ADDR_WIDTH, ARLEN out 8, ARSIZE out 3, ARVALID out 1, ARREADY in 1: read address channel.
- RDATA in DATA_WIDTH, RRESP in 2, RVALID in 1, RLAST in 1, RREADY out 1: read data channel.

Behaviour:
- Reset (asynchronous, ARESETn low):
  - State is IDLE.
  - All VALID outputs, BREADY, RREADY, done and wdata_ready are 0.
  - resp, the beat counter and the captured address, length and size registers are 0.
  - cmd_ready is 1.
  - Reset asserted mid-burst abandons the transaction immediately; no done pulse is produced.
- States: IDLE, REJ, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture addr, len and size; clear beat_cnt and worst_resp; drop cmd_ready.
  - Legality check at capture. The command is illegal if:
    - (cmd_addr[11:0] + ((cmd_len+1) << cmd_size)) > 4096 (compute at 14 bits), or
    - cmd_size > log2(DATA_WIDTH/8).
  - Illegal command -> REJ. Legal command -> AW if cmd_write, else AR.
- REJ:
  - No AXI traffic.
  - done=1, resp=2'b10 for one cycle, then IDLE.
- AW:
  - AWVALID=1 with AWADDR, AWLEN and AWSIZE held stable until AWREADY is sampled high.
  - Then deassert AWVALID -> W.
- W:
  - WVALID=wdata_valid; WDATA=wdata_in (combinational pass); wdata_ready=WREADY.
  - WLAST = (beat_cnt == len).
  - Each WVALID&&WREADY increments beat_cnt.
  - On the beat with WLAST -> B, with WVALID and wdata_ready forced low from the next cycle.
- B:
  - BREADY=1.
  - On BVALID: done=1, resp=BRESP, BREADY drops -> IDLE.
- AR:
  - ARVALID=1 with ARADDR, ARLEN and ARSIZE held until ARREADY.
  - Then -> R.
- R:
  - RREADY=rdata_ready; rdata_valid=RVALID; rdata_out=RDATA.
  - Each RVALID&&RREADY:
    - beat_cnt increments.
    - worst_resp = max(worst_resp, RRESP).
  - Termination on the first accepted beat with RLAST=1, or when beat_cnt==len:
    - done=1; resp=worst_resp merged with the terminating beat's RRESP -> IDLE.
  - Early RLAST (beat_cnt<len) terminates the transaction with resp forced to at least 2'b10.
  - Beats after termination are not accepted (RREADY=0 outside R).
- Beat counter:
  - 9 bits, so len=255 (256 beats) does not wrap.
  - done is high only in the cycle of the final handshake.
- No timeout; a stalled slave holds the FSM indefinitely.

Test Plan:
- Single-beat write: addr=0x0010, len=0, size=2, data 0xDEADBEEF.
  - AW handshake, then 1 W beat with WLAST=1, then B OKAY.
  - done pulse with resp=00.
- 4-beat write then read at 0x0100, size=2, data 0x11,0x22,0x33,0x44.
  - WLAST on beat 4 only.
  - Readback rdata_out sequence 0x11,0x22,0x33,0x44, resp=00.
- 4KB cross: addr=0x0FF8, len=3, size=2.
  - No AWVALID/ARVALID ever asserted.
  - done one cycle after accept with resp=10.
- Backpressure:
  - wdata_valid toggling every other cycle -> WVALID mirrors it; exactly len+1 beats counted.
  - rdata_ready low for 3 cycles mid-read -> RREADY low; no beat lost.
- Slave error: read at addr=0x1000, beyond 1024 words.
  - Slave returns an RLAST SLVERR beat early.
  - done with resp=10; FSM back in IDLE; cmd_ready=1.
- Reset during the W state of an 8-beat write:
  - All VALIDs 0 asynchronously; cmd_ready=1 after release; no done pulse.
  - Next command completes normally.
